// File: rtl/pulse_trigger_seq_pkg.sv
// rtl/pulse_trigger_seq_pkg.sv - shared constants, register map and state encoding for the trigger sequencer
package pulse_trigger_seq_pkg;

  localparam logic [7:0]  VERSION_DEFAULT = 8'd1;

  localparam logic [3:0]  ADDR_VERSION   = 4'd0;
  localparam logic [3:0]  ADDR_STATUS    = 4'd1;
  localparam logic [3:0]  ADDR_CONF      = 4'd2;
  localparam logic [3:0]  ADDR_PERIOD_LO = 4'd3;
  localparam logic [3:0]  ADDR_PERIOD_HI = 4'd4;
  localparam logic [3:0]  ADDR_COUNT_LO  = 4'd5;
  localparam logic [3:0]  ADDR_COUNT_HI  = 4'd6;
  localparam logic [3:0]  ADDR_HIGH      = 4'd7;
  localparam logic [3:0]  ADDR_TRIG_LO   = 4'd8;
  localparam logic [3:0]  ADDR_TRIG_HI   = 4'd9;
  localparam logic [3:0]  ADDR_STOP      = 4'd10;

  localparam logic [15:0] CONF_COUNT_RST = 16'd1;
  localparam logic [7:0]  CONF_HIGH_RST  = 8'd1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HIGH      = 2'd1,
    ST_LOW       = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  function automatic logic [7:0] high_eff(input logic [7:0] high);
    return (high == 8'd0) ? 8'd1 : high;
  endfunction

  // The period must leave at least one low cycle after the strobe.
  function automatic logic [16:0] period_eff(input logic [15:0] period, input logic [7:0] high);
    logic [16:0] min_period;
    min_period = {9'd0, high} + 17'd1;
    return ({1'b0, period} > min_period) ? {1'b0, period} : min_period;
  endfunction

endpackage

// File: rtl/pulse_trigger_seq_regs.sv
// rtl/pulse_trigger_seq_regs.sv - bus decode, configuration registers and registered read mux
module pulse_trigger_seq_regs
  import pulse_trigger_seq_pkg::*;
#(
  parameter int unsigned ABUSWIDTH = 16,
  parameter logic [7:0]  VERSION   = VERSION_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [ABUSWIDTH-1:0] i_add,
  input  logic [7:0]           i_data,
  input  logic                 i_wr,
  input  logic                 i_rd,
  output logic [7:0]           o_data,
  input  logic                 i_busy,
  input  logic                 i_done,
  input  logic [15:0]          i_trig_cnt,
  output logic                 o_soft_rst,
  output logic                 o_start,
  output logic                 o_stop,
  output logic                 o_ext_en,
  output logic                 o_wait_done,
  output logic [15:0]          o_period,
  output logic [15:0]          o_count,
  output logic [7:0]           o_high
);

  logic        w_sel;
  logic [3:0]  w_reg;
  logic        w_wr;
  logic        w_rst;
  logic [7:0]  w_rd_data;

  logic        r_ext_en;
  logic        r_wait_done;
  logic [15:0] r_period;
  logic [15:0] r_count;
  logic [7:0]  r_high;
  logic [7:0]  r_data;

  // Only the low 16 addresses are mapped; anything above must decode to nothing.
  assign w_sel      = (i_add[ABUSWIDTH-1:4] == '0);
  assign w_reg      = i_add[3:0];
  assign w_wr       = i_wr && w_sel;
  assign o_soft_rst = w_wr && (w_reg == ADDR_VERSION);
  assign o_start    = w_wr && (w_reg == ADDR_STATUS);
  assign o_stop     = w_wr && (w_reg == ADDR_STOP);
  assign w_rst      = i_rst || o_soft_rst;

  always_comb begin
    w_rd_data = 8'd0;
    if (w_sel) begin
      case (w_reg)
        ADDR_VERSION:   w_rd_data = VERSION;
        ADDR_STATUS:    w_rd_data = {6'd0, i_busy, i_done};
        ADDR_CONF:      w_rd_data = {6'd0, r_wait_done, r_ext_en};
        ADDR_PERIOD_LO: w_rd_data = r_period[7:0];
        ADDR_PERIOD_HI: w_rd_data = r_period[15:8];
        ADDR_COUNT_LO:  w_rd_data = r_count[7:0];
        ADDR_COUNT_HI:  w_rd_data = r_count[15:8];
        ADDR_HIGH:      w_rd_data = r_high;
        ADDR_TRIG_LO:   w_rd_data = i_trig_cnt[7:0];
        ADDR_TRIG_HI:   w_rd_data = i_trig_cnt[15:8];
        default:        w_rd_data = 8'd0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_rst) begin
      r_ext_en    <= 1'b0;
      r_wait_done <= 1'b0;
      r_period    <= 16'd0;
      r_count     <= CONF_COUNT_RST;
      r_high      <= CONF_HIGH_RST;
      r_data      <= 8'd0;
    end else begin
      if (w_wr) begin
        case (w_reg)
          ADDR_CONF: begin
            r_ext_en    <= i_data[0];
            r_wait_done <= i_data[1];
          end
          ADDR_PERIOD_LO: r_period[7:0]  <= i_data;
          ADDR_PERIOD_HI: r_period[15:8] <= i_data;
          ADDR_COUNT_LO:  r_count[7:0]   <= i_data;
          ADDR_COUNT_HI:  r_count[15:8]  <= i_data;
          ADDR_HIGH:      r_high         <= i_data;
          default: ;
        endcase
      end
      if (i_rd) r_data <= w_rd_data;
    end
  end

  assign o_data      = r_data;
  assign o_ext_en    = r_ext_en;
  assign o_wait_done = r_wait_done;
  assign o_period    = r_period;
  assign o_count     = r_count;
  assign o_high      = r_high;

endmodule

// File: rtl/pulse_trigger_seq.sv
// rtl/pulse_trigger_seq.sv - start-strobe train sequencer feeding the pulse generator EXT_START input
module pulse_trigger_seq
  import pulse_trigger_seq_pkg::*;
#(
  parameter int unsigned ABUSWIDTH = 16,
  parameter logic [7:0]  VERSION   = VERSION_DEFAULT
) (
  input  logic                 BUS_CLK,
  input  logic                 RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 BUS_WR,
  input  logic                 BUS_RD,
  input  logic                 TRIG_IN,
  input  logic                 GEN_DONE,
  output logic                 EXT_START,
  output logic                 BUSY
);

  logic        w_soft_rst;
  logic        w_start;
  logic        w_stop;
  logic        w_rst;
  logic        w_conf_ext_en;
  logic        w_conf_wait_done;
  logic [15:0] w_conf_period;
  logic [15:0] w_conf_count;
  logic [7:0]  w_conf_high;
  logic [7:0]  w_high_eff;
  logic [16:0] w_period_eff;
  logic        w_go;
  logic        w_last;
  logic        w_high_end;
  logic        w_period_end;
  logic        w_enter_high;
  state_t      w_state_nxt;

  state_t      r_state;
  logic        r_done;
  logic        r_arm;
  logic [15:0] r_trig_cnt;
  logic [16:0] r_per_cnt;
  logic [2:0]  r_trig_sync;
  logic        r_trig_rise;

  pulse_trigger_seq_regs #(
    .ABUSWIDTH (ABUSWIDTH),
    .VERSION   (VERSION)
  ) u_regs (
    .i_clk       (BUS_CLK),
    .i_rst       (RST),
    .i_add       (BUS_ADD),
    .i_data      (BUS_DATA_IN),
    .i_wr        (BUS_WR),
    .i_rd        (BUS_RD),
    .o_data      (BUS_DATA_OUT),
    .i_busy      (BUSY),
    .i_done      (r_done),
    .i_trig_cnt  (r_trig_cnt),
    .o_soft_rst  (w_soft_rst),
    .o_start     (w_start),
    .o_stop      (w_stop),
    .o_ext_en    (w_conf_ext_en),
    .o_wait_done (w_conf_wait_done),
    .o_period    (w_conf_period),
    .o_count     (w_conf_count),
    .o_high      (w_conf_high)
  );

  assign w_rst        = RST || w_soft_rst;
  assign w_high_eff   = high_eff(w_conf_high);
  assign w_period_eff = period_eff(w_conf_period, w_high_eff);
  assign w_go         = w_start || (w_conf_ext_en && r_trig_rise);
  assign w_last       = (w_conf_count != 16'd0) && (r_trig_cnt == w_conf_count);
  // >= rather than == so a CONF shrink mid-strobe cannot skip the terminal count.
  assign w_high_end   = (r_per_cnt >= ({9'd0, w_high_eff} - 17'd1));
  assign w_period_end = (r_per_cnt >= (w_period_eff - 17'd1));
  assign w_enter_high = (w_state_nxt == ST_HIGH) && (r_state != ST_HIGH);

  always_comb begin
    w_state_nxt = r_state;
    EXT_START   = 1'b0;
    BUSY        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        BUSY = 1'b0;
        if (w_go) w_state_nxt = ST_HIGH;
      end
      ST_HIGH: begin
        EXT_START = 1'b1;
        if (w_high_end) w_state_nxt = ST_LOW;
      end
      ST_LOW: begin
        if (w_period_end) begin
          if (w_last)                w_state_nxt = ST_IDLE;
          else if (w_conf_wait_done) w_state_nxt = ST_WAIT_DONE;
          else                       w_state_nxt = ST_HIGH;
        end
      end
      ST_WAIT_DONE: begin
        if (r_arm && GEN_DONE) w_state_nxt = ST_HIGH;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_stop) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge BUS_CLK) begin
    if (w_rst) begin
      r_state     <= ST_IDLE;
      r_done      <= 1'b1;
      r_arm       <= 1'b0;
      r_trig_cnt  <= 16'd0;
      r_per_cnt   <= 17'd0;
      r_trig_sync <= 3'd0;
      r_trig_rise <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      // Two synchroniser flops, a history flop, then a registered rising-edge pulse.
      r_trig_sync <= {r_trig_sync[1:0], TRIG_IN};
      r_trig_rise <= r_trig_sync[1] && !r_trig_sync[2];

      if (r_state == ST_IDLE && w_state_nxt == ST_HIGH) begin
        r_done     <= 1'b0;
        r_trig_cnt <= 16'd0;
      end else begin
        if (r_state != ST_IDLE && w_state_nxt == ST_IDLE) r_done <= 1'b1;
        if (r_state == ST_HIGH && r_per_cnt == 17'd0) r_trig_cnt <= r_trig_cnt + 16'd1;
      end

      if (w_enter_high)                                    r_per_cnt <= 17'd0;
      else if (r_state == ST_HIGH || r_state == ST_LOW)    r_per_cnt <= r_per_cnt + 17'd1;

      // Arm tracks a GEN_DONE low seen anywhere since the current strobe began.
      if (w_enter_high)                            r_arm <= 1'b0;
      else if (!GEN_DONE && r_state != ST_IDLE)    r_arm <= 1'b1;
    end
  end

endmodule
